// File: rtl/pipeline_issue.sv
// rtl/pipeline_issue.sv - instruction issue unit: input FIFO, RAW-hazard stalling, bubble insertion, illegal-word rejection
module pipeline_issue #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         HAZ_WINDOW = 2,
    parameter logic [3:0] NOP_REG    = 4'd15,
    parameter logic [7:0] NOP_ADDR   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    output logic [3:0]  iss_func,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [7:0]  iss_addr,
    output logic        iss_valid,
    output logic        err_illegal,
    output logic        busy,
    output logic [15:0] issued_cnt,
    output logic [15:0] stall_cnt
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] NOP_FUNC = 4'b0011;

    logic [23:0]           mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [HAZ_WINDOW-1:0] hist_valid;
    logic [3:0]            hist_rd [HAZ_WINDOW];

    logic        empty, push, pop;
    logic [23:0] head;
    logic [3:0]  h_func, h_rd, h_rs1, h_rs2;
    logic        use_rs1, use_rs2, illegal, hazard;
    logic        do_issue, do_drop, do_stall;

    assign empty  = (wr_ptr == rd_ptr);
    assign head   = mem[rd_ptr[AW-1:0]];
    assign h_func = head[23:20];
    assign h_rd   = head[19:16];
    assign h_rs1  = head[15:12];
    assign h_rs2  = head[11:8];

    assign push = in_valid && in_ready;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (h_func)
            4'b0000, 4'b0001, 4'b0010,
            4'b0101, 4'b0110, 4'b0111: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            4'b0011, 4'b1000, 4'b1010, 4'b1011: use_rs1 = 1'b1;
            4'b0100, 4'b1001:                   use_rs2 = 1'b1;
            default: ;
        endcase
    end

    // Only sources the opcode actually reads are compared against in-flight producers.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WINDOW; i++) begin
            if (hist_valid[i] && ((use_rs1 && h_rs1 == hist_rd[i]) ||
                                  (use_rs2 && h_rs2 == hist_rd[i])))
                hazard = 1'b1;
        end
    end

    assign illegal  = (h_func >= 4'b1100) || (h_rd == NOP_REG);
    assign do_drop  = !empty && illegal;
    assign do_stall = !empty && !illegal && hazard;
    assign do_issue = !empty && !illegal && !hazard;
    assign pop      = do_issue || do_drop;

    assign wr_ptr_n = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};

    assign busy = !empty || (|hist_valid);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_ready    <= 1'b1;
            iss_func    <= NOP_FUNC;
            iss_rd      <= NOP_REG;
            iss_rs1     <= NOP_REG;
            iss_rs2     <= NOP_REG;
            iss_addr    <= NOP_ADDR;
            iss_valid   <= 1'b0;
            err_illegal <= 1'b0;
            issued_cnt  <= 16'd0;
            stall_cnt   <= 16'd0;
            hist_valid  <= '0;
            for (int i = 0; i < HAZ_WINDOW; i++)
                hist_rd[i] <= NOP_REG;
        end else begin
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            // Registered full flag: reflects occupancy after this edge's push/pop.
            in_ready    <= ((wr_ptr_n - rd_ptr_n) != (AW+1)'(FIFO_DEPTH));
            iss_valid   <= do_issue;
            err_illegal <= do_drop;
            if (do_issue) begin
                iss_func <= h_func;
                iss_rd   <= h_rd;
                iss_rs1  <= h_rs1;
                iss_rs2  <= h_rs2;
                iss_addr <= head[7:0];
            end else begin
                iss_func <= NOP_FUNC;
                iss_rd   <= NOP_REG;
                iss_rs1  <= NOP_REG;
                iss_rs2  <= NOP_REG;
                iss_addr <= NOP_ADDR;
            end
            for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
                hist_valid[i] <= hist_valid[i-1];
                hist_rd[i]    <= hist_rd[i-1];
            end
            hist_valid[0] <= do_issue;
            hist_rd[0]    <= h_rd;
            if (do_issue)
                issued_cnt <= issued_cnt + 16'd1;
            if (do_stall)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_issue.sv
// tb/tb_pipeline_issue.sv - directed self-checking bench for pipeline_issue
module tb_pipeline_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_instr = 24'h0;
    logic [3:0]  iss_func, iss_rd, iss_rs1, iss_rs2;
    logic [7:0]  iss_addr;
    logic        iss_valid, err_illegal, busy;
    logic [15:0] issued_cnt, stall_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [23:0] W_A   = 24'h031210;
    localparam logic [23:0] W_B   = 24'h054620;
    localparam logic [23:0] W_SUB = 24'h143110;
    localparam logic [23:0] W_NOT = 24'h856300;
    localparam logic [25:0] BUB   = {2'b00, 24'h3FFFFF};
    localparam logic [25:0] ILL   = {2'b01, 24'h3FFFFF};

    // Log entry: {in_ready, busy, iss_valid, err_illegal, func, rd, rs1, rs2, addr}
    logic [27:0] log_q[$];
    logic        log_en = 1'b0;

    pipeline_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .iss_func   (iss_func),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_addr   (iss_addr),
        .iss_valid  (iss_valid),
        .err_illegal(err_illegal),
        .busy       (busy),
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (log_en)
            log_q.push_back({in_ready, busy, iss_valid, err_illegal,
                             iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr});

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [25:0] real_slot(input logic [23:0] w);
        return {2'b10, w};
    endfunction

    function automatic int first_with(input int b);
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i][b]) return i;
        return -1;
    endfunction

    function automatic logic [25:0] log_at(input int idx);
        if (idx < 0 || idx >= log_q.size()) return 'x;
        return log_q[idx][25:0];
    endfunction

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < log_q.size(); i++)
            if (log_q[i][25]) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_instr = 24'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        log_en = 1'b0;
        log_q.delete();
    endtask

    task automatic start_log();
        log_q.delete();
        log_en = 1'b1;
    endtask

    task automatic push_word(input logic [23:0] w);
        int   waited = 0;
        logic ok;
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = w;
        while (1) begin
            ok = in_ready;
            @(posedge clk);
            if (ok) break;
            waited++;
            if (waited > 50) begin
                total++; bad++;
                $display("FAIL push_timeout word=%h never accepted", w);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_instr = 24'h0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({iss_valid, err_illegal, iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr} !== BUB) begin
            bad++;
            $display("FAIL reset_slot got=%h exp=%h",
                     {iss_valid, err_illegal, iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr}, BUB);
        end
        total++;
        if ({in_ready, busy} !== 2'b10) begin
            bad++; $display("FAIL reset_ready_busy got=%b exp=10", {in_ready, busy});
        end
        total++;
        if ({issued_cnt, stall_cnt} !== 32'h0) begin
            bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", issued_cnt, stall_cnt);
        end
    endtask

    task automatic test_independent();
        int f;
        logic [25:0] exp_q[$];
        do_reset();
        start_log();
        push_word(W_A);
        push_word(W_B);
        idle();
        run(4);
        exp_q = '{real_slot(W_A), real_slot(W_B)};
        f = first_with(25);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (f < 0 || log_at(f + i) !== exp_q[i]) begin
                bad++; $display("FAIL indep_slot%0d got=%h exp=%h", i, log_at(f + i), exp_q[i]);
            end
        end
        total++;
        if (stall_cnt !== 16'd0 || issued_cnt !== 16'd2) begin
            bad++; $display("FAIL indep_counters got=%0d/%0d exp=2/0", issued_cnt, stall_cnt);
        end
    endtask

    task automatic test_raw_stall();
        int f;
        logic [25:0] exp_q[$];
        do_reset();
        start_log();
        push_word(W_A);
        push_word(W_SUB);
        idle();
        run(8);
        exp_q = '{real_slot(W_A), BUB, BUB, real_slot(W_SUB)};
        f = first_with(25);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (f < 0 || log_at(f + i) !== exp_q[i]) begin
                bad++; $display("FAIL raw_slot%0d got=%h exp=%h", i, log_at(f + i), exp_q[i]);
            end
        end
        total++;
        if (stall_cnt !== 16'd2 || issued_cnt !== 16'd2) begin
            bad++; $display("FAIL raw_counters got=%0d/%0d exp=2/2", issued_cnt, stall_cnt);
        end
        total++;
        if (f < 0 || f + 5 >= log_q.size() || log_q[f+4][26] !== 1'b1 || log_q[f+5][26] !== 1'b0) begin
            bad++; $display("FAIL raw_busy_fall got=%b%b exp=10",
                            (f >= 0 && f + 4 < log_q.size()) ? log_q[f+4][26] : 1'bx,
                            (f >= 0 && f + 5 < log_q.size()) ? log_q[f+5][26] : 1'bx);
        end
    endtask

    task automatic test_unused_source();
        int f;
        logic [25:0] exp_q[$];
        do_reset();
        start_log();
        push_word(W_A);
        push_word(W_NOT);
        idle();
        run(4);
        exp_q = '{real_slot(W_A), real_slot(W_NOT)};
        f = first_with(25);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (f < 0 || log_at(f + i) !== exp_q[i]) begin
                bad++; $display("FAIL unused_slot%0d got=%h exp=%h", i, log_at(f + i), exp_q[i]);
            end
        end
        total++;
        if (stall_cnt !== 16'd0) begin
            bad++; $display("FAIL unused_stall got=%0d exp=0", stall_cnt);
        end
    endtask

    task automatic test_illegal();
        int f;
        logic [25:0] exp_q[$];
        do_reset();
        start_log();
        push_word(24'hC12345);
        push_word(24'h0F1200);
        push_word(W_A);
        idle();
        run(5);
        exp_q = '{ILL, ILL, real_slot(W_A)};
        f = first_with(24);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (f < 0 || log_at(f + i) !== exp_q[i]) begin
                bad++; $display("FAIL illegal_slot%0d got=%h exp=%h", i, log_at(f + i), exp_q[i]);
            end
        end
        total++;
        if (issued_cnt !== 16'd1 || count_valid() !== 1) begin
            bad++; $display("FAIL illegal_issued got=%0d/%0d exp=1/1", issued_cnt, count_valid());
        end
    endtask

    task automatic test_full_fifo();
        int f;
        int ready_low = 0;
        logic [25:0] exp_q[$];
        do_reset();
        start_log();
        push_word(W_A);
        for (int i = 1; i <= 5; i++)
            push_word(24'h133100 | 24'(i));
        idle();
        run(20);
        exp_q = '{real_slot(W_A)};
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(BUB);
            exp_q.push_back(BUB);
            exp_q.push_back(real_slot(24'h133100 | 24'(i)));
        end
        f = first_with(25);
        for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (f < 0 || log_at(f + i) !== exp_q[i]) begin
                bad++; $display("FAIL full_slot%0d got=%h exp=%h", i, log_at(f + i), exp_q[i]);
            end
        end
        for (int i = 0; i < log_q.size(); i++)
            if (!log_q[i][27]) ready_low++;
        total++;
        if (ready_low == 0) begin
            bad++; $display("FAIL full_ready_drop got=%0d low cycles exp>0", ready_low);
        end
        total++;
        if (count_valid() !== 6 || issued_cnt !== 16'd6 || stall_cnt !== 16'd10) begin
            bad++; $display("FAIL full_counts got=%0d/%0d/%0d exp=6/6/10",
                            count_valid(), issued_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        int f;
        do_reset();
        push_word(W_A);
        push_word(W_SUB);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({iss_valid, err_illegal, iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr} !== BUB ||
            busy !== 1'b0 || issued_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midrst_state got=%h busy=%b cnt=%0d/%0d exp=%h busy=0 cnt=0/0",
                     {iss_valid, err_illegal, iss_func, iss_rd, iss_rs1, iss_rs2, iss_addr},
                     busy, issued_cnt, stall_cnt, BUB);
        end
        start_log();
        run(3);
        total++;
        if (count_valid() !== 0) begin
            bad++; $display("FAIL midrst_discard got=%0d issued exp=0", count_valid());
        end
        push_word(W_A);
        idle();
        run(4);
        f = first_with(25);
        total++;
        if (f < 0 || log_at(f) !== real_slot(W_A) || count_valid() !== 1 || stall_cnt !== 16'd0) begin
            bad++; $display("FAIL midrst_reissue got=%h n=%0d stall=%0d exp=%h n=1 stall=0",
                            log_at(f), count_valid(), stall_cnt, real_slot(W_A));
        end
    endtask

    initial begin
        test_reset();
        test_independent();
        test_raw_stall();
        test_unused_source();
        test_illegal();
        test_full_fifo();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
